// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: round-robin arbitration among NREQ writeback
// requesters, a one-cycle registered write port, and a busy scoreboard for hazard checks.
module rf_wb_ctrl #(
  parameter int DATAWIDTH = 32,
  parameter int REGISTERS = 32,
  parameter int INDEX     = $clog2(REGISTERS),
  parameter int NREQ      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*INDEX-1:0]     req_addr,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      issue_valid,
  input  logic [INDEX-1:0]          issue_rd,
  input  logic [INDEX-1:0]          ra_1,
  input  logic [INDEX-1:0]          ra_2,
  output logic                      hazard_1,
  output logic                      hazard_2,
  output logic                      hazard_rd,
  output logic                      werf,
  output logic [INDEX-1:0]          wa,
  output logic [DATAWIDTH-1:0]      wd
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: requester i transfers on a cycle where req_valid[i] && req_ready[i].
  // req_ready depends only on req_valid and rr_ptr_q, never on its own history.

  logic [PTRW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      grant;
  logic [PTRW-1:0]      grant_idx;
  logic                 xfer;
  logic [INDEX-1:0]     xfer_addr;
  logic [DATAWIDTH-1:0] xfer_data;

  logic [REGISTERS-1:0] busy_q, busy_d;
  logic                 werf_q, werf_d;
  logic [INDEX-1:0]     wa_q, wa_d;
  logic [DATAWIDTH-1:0] wd_q, wd_d;

  // Search starts at rr_ptr_q and wraps, so the first valid hit is the winner.
  always_comb begin
    int  idx_i;
    logic found;
    grant     = '0;
    grant_idx = '0;
    xfer_addr = '0;
    xfer_data = '0;
    found     = 1'b0;
    idx_i     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_i = int'(rr_ptr_q) + k;
      if (idx_i >= NREQ) idx_i = idx_i - NREQ;
      if (!found && req_valid[PTRW'(idx_i)]) begin
        found                 = 1'b1;
        grant[PTRW'(idx_i)]   = 1'b1;
        grant_idx             = PTRW'(idx_i);
        xfer_addr             = req_addr[idx_i*INDEX +: INDEX];
        xfer_data             = req_data[idx_i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    int nxt;
    rr_ptr_d = rr_ptr_q;
    nxt      = int'(grant_idx) + 1;
    if (nxt >= NREQ) nxt = 0;
    if (xfer) rr_ptr_d = PTRW'(nxt);
  end

  // Clear first, then set, so an issue to the same register wins the collision.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < REGISTERS; r++) begin
      if (xfer && (xfer_addr != '0) && (int'(xfer_addr) == r)) busy_d[r] = 1'b0;
      if (issue_valid && (issue_rd != '0) && (int'(issue_rd) == r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Writes to register 0 are granted and retired but never reach the file.
  always_comb begin
    werf_d = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    if (xfer) begin
      werf_d = (xfer_addr != '0);
      wa_d   = xfer_addr;
      wd_d   = xfer_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      busy_q   <= '0;
      werf_q   <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      werf_q   <= werf_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  function automatic logic busy_at(input logic [REGISTERS-1:0] b, input logic [INDEX-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int r = 1; r < REGISTERS; r++) begin
      if (int'(a) == r) hit = b[r];
    end
    return hit;
  endfunction

  assign hazard_1  = busy_at(busy_q, ra_1);
  assign hazard_2  = busy_at(busy_q, ra_2);
  assign hazard_rd = busy_at(busy_q, issue_rd);

  assign werf = werf_q;
  assign wa   = wa_q;
  assign wd   = wd_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed steps followed by random traffic, all checked
// against a behavioural model of arbitration, writeback and the busy scoreboard.
module tb_rf_wb_ctrl;

  localparam int DW   = 32;
  localparam int REGS = 32;
  localparam int IDX  = 5;
  localparam int NR   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*IDX-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             issue_valid;
  logic [IDX-1:0]   issue_rd, ra_1, ra_2;
  logic             hazard_1, hazard_2, hazard_rd;
  logic             werf;
  logic [IDX-1:0]   wa;
  logic [DW-1:0]    wd;

  int n_cmp  = 0;
  int n_fail = 0;

  bit             m_busy [REGS];
  int             m_ptr;
  bit             m_werf;
  logic [IDX-1:0] m_wa;
  logic [DW-1:0]  m_wd;

  rf_wb_ctrl #(.DATAWIDTH(DW), .REGISTERS(REGS), .INDEX(IDX), .NREQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .ra_1(ra_1), .ra_2(ra_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2), .hazard_rd(hazard_rd),
    .werf(werf), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    m_ptr  = 0;
    m_werf = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
  endtask

  function automatic int model_grant(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic bit model_busy(input logic [IDX-1:0] a);
    return (a != 0) && m_busy[a];
  endfunction

  // Called at a falling edge: drive, check, advance the model across the next rising edge.
  task automatic step(input logic [NR-1:0] v,
                      input logic [IDX-1:0] a0, input logic [IDX-1:0] a1, input logic [IDX-1:0] a2,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic iv, input logic [IDX-1:0] ird,
                      input logic [IDX-1:0] r1, input logic [IDX-1:0] r2);
    int             g;
    logic [IDX-1:0] ga;
    logic [DW-1:0]  gd;
    req_valid   = v;
    req_addr    = {a2, a1, a0};
    req_data    = {d2, d1, d0};
    issue_valid = iv;
    issue_rd    = ird;
    ra_1        = r1;
    ra_2        = r2;
    #1;
    g = model_grant(v);
    chk("req_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
    chk("hazard_1", hazard_1, model_busy(r1));
    chk("hazard_2", hazard_2, model_busy(r2));
    chk("hazard_rd", hazard_rd, model_busy(ird));
    chk("werf", werf, m_werf);
    if (m_werf) begin
      chk("wa", wa, m_wa);
      chk("wd", wd, m_wd);
    end
    if (g >= 0) begin
      ga     = (g == 0) ? a0 : (g == 1) ? a1 : a2;
      gd     = (g == 0) ? d0 : (g == 1) ? d1 : d2;
      m_werf = (ga != 0);
      m_wa   = ga;
      m_wd   = gd;
      m_ptr  = (g + 1) % NR;
      if (ga != 0) m_busy[ga] = 1'b0;
    end else begin
      m_werf = 1'b0;
    end
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic [IDX-1:0] r1, input logic [IDX-1:0] r2);
    step('0, 0, 0, 0, 0, 0, 0, 1'b0, 0, r1, r2);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; ra_1 = '0; ra_2 = '0;
    model_reset();

    // Reset state, and arbitration from pointer 0 while held in reset
    #1;
    chk("rst_werf", werf, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_ready_none", req_ready, 0);
    req_valid = 3'b111; issue_valid = 1'b1; issue_rd = 5'd6; ra_1 = 5'd6;
    #1;
    chk("rst_ready_all", req_ready, 3'b001);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_hold", req_ready, 3'b001);
    chk("rst_werf_hold", werf, 0);
    chk("rst_busy_hold", hazard_1, 0);
    @(negedge clk);
    req_valid = '0; issue_valid = 1'b0;
    rst_n = 1'b1;

    // Round robin: grants 0,1,2,0 then writes in the same order
    for (int i = 0; i < 4; i++)
      step(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0 + i, 32'hB0 + i, 32'hC0 + i, 1'b0, 0, 0, 0);

    // Single writeback from requester 1
    step(3'b010, 0, 5'd5, 0, 0, 32'hDEADBEEF, 0, 1'b0, 0, 0, 0);
    #1;
    chk("single_werf", werf, 1);
    chk("single_wa", wa, 5);
    chk("single_wd", wd, 32'hDEADBEEF);
    idle(0, 0);

    // Register 0 protection
    step(3'b001, 0, 0, 0, 32'h1234, 0, 0, 1'b0, 0, 0, 0);
    step('0, 0, 0, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    idle(0, 0);

    // Scoreboard set, hold during the clearing transfer, fall afterwards
    step('0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd7, 5'd7, 0);
    step(3'b100, 0, 0, 5'd7, 0, 0, 32'h7777, 1'b0, 0, 5'd7, 0);
    idle(5'd7, 0);

    // Set/clear collision on register 9
    step('0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd9, 0, 0);
    step(3'b001, 5'd9, 0, 0, 32'h9999, 0, 0, 1'b1, 5'd9, 5'd9, 0);
    idle(5'd9, 5'd9);

    // Mid-operation reset with busy[3], busy[4] and pointer at 2
    step('0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd3, 0, 0);
    step('0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd4, 5'd3, 0);
    step(3'b010, 0, 5'd12, 0, 0, 32'hCAFE, 0, 1'b0, 0, 5'd3, 5'd4);
    ra_1 = 5'd3; ra_2 = 5'd4; req_valid = '0; issue_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_werf", werf, 0);
    chk("mid_rst_haz1", hazard_1, 0);
    chk("mid_rst_haz2", hazard_2, 0);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 0, 5'd3, 5'd4);
    idle(0, 0);

    // Random traffic on a small address window so hazards and collisions recur
    for (int i = 0; i < 400; i++) begin
      step(NR'($urandom_range(0, 7)),
           IDX'($urandom_range(0, 7)), IDX'($urandom_range(0, 7)), IDX'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), IDX'($urandom_range(0, 7)),
           IDX'($urandom_range(0, 7)), IDX'($urandom_range(0, 7)));
    end
    idle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, register data width.
REQ-002 SHALL have parameter REGISTERS, default 32, number of architectural registers.
REQ-003 SHALL have parameter INDEX, default $clog2(REGISTERS), register address width.
REQ-004 SHALL have parameter NREQ, default 3, number of writeback requesters (2..4).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid  input  NREQ  per-requester writeback request.
REQ-008 SHALL have port req_addr  input  NREQ*INDEX  flattened destination addresses; requester i occupies bits [i*INDEX +: INDEX].
REQ-009 SHALL have port req_data  input  NREQ*DATAWIDTH  flattened write data; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-010 SHALL have port req_ready  output  NREQ  one-hot grant; at most one bit high per cycle.
REQ-011 SHALL have port issue_valid  input  1  an instruction with a destination register issues this cycle.
REQ-012 SHALL have port issue_rd  input  INDEX  destination of the issuing instruction.
REQ-013 SHALL have port ra_1, ra_2  input  INDEX each  source addresses to check for hazards.
REQ-014 SHALL have port hazard_1, hazard_2, hazard_rd  output  1 each  pending-write flags for ra_1, ra_2 and issue_rd.
REQ-015 SHALL have port werf, wa, wd  output  1 / INDEX / DATAWIDTH  register-file write-port drive.

Function
REQ-016 SHALL transfer requester i when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-017 SHALL compute req_ready combinationally: the first valid requester at or after rr_ptr in ascending modulo-NREQ order; all zero when no requester is valid.
REQ-018 SHALL update rr_ptr after each transfer to (granted index + 1) mod NREQ; rr_ptr SHALL be held when there is no transfer.
REQ-019 SHALL register the winning request: werf, wa and wd reflect the transfer one cycle later (latency 1); werf SHALL be 0 in cycles following no transfer.
REQ-020 SHALL grant a request addressed to register 0, but SHALL force werf to 0 for it, leaving register 0 constant.
REQ-021 SHALL keep a scoreboard busy[REGISTERS-1:0]: issue_valid with issue_rd != 0 sets busy[issue_rd]; a transfer with addr != 0 clears busy[addr].
REQ-022 SHALL give set priority when a set and a clear hit the same register in one cycle (busy stays 1).
REQ-023 SHALL ignore issue_valid with issue_rd == 0 (no scoreboard change, hazard_rd = 0).
REQ-024 SHALL drive hazard_1 = busy[ra_1], hazard_2 = busy[ra_2] and hazard_rd = busy[issue_rd] combinationally from the registered scoreboard; address 0 always reads 0.
REQ-025 SHALL NOT let a same-cycle transfer clear a hazard flag; the flag falls in the cycle after the clearing edge, when werf writes the data.
REQ-026 SHALL never grant a requester whose req_valid is low, and SHALL keep req_ready independent of req_ready history except through rr_ptr.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force werf=0, wa=0, wd=0, busy=all zero and rr_ptr=0.
REQ-028 SHALL make req_ready follow REQ-017 with rr_ptr=0 during reset; transfers seen during reset SHALL have no effect.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n goes high; pending writes from before reset are discarded.

Verification
REQ-030 SHALL cover round-robin: all three requesters valid for 4 cycles from reset -> grants 0,1,2,0; werf writes follow one cycle later in the same order.
REQ-031 SHALL cover single writeback: req_valid=3'b010, addr=5, data=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle werf=1, wa=5, wd=0xDEADBEEF.
REQ-032 SHALL cover x0 protection: requester 0 writes addr=0, data=0x1234 -> ready=1, next cycle werf=0; issue_rd=0 -> hazard_rd=0, busy unchanged.
REQ-033 SHALL cover the scoreboard: issue rd=7 -> next cycle, with ra_1=7, hazard_1=1; a transfer to 7 -> hazard_1=0 in the following cycle.
REQ-034 SHALL cover set/clear collision: issue rd=9 and a transfer to 9 in the same cycle -> busy[9]=1 afterwards.
REQ-035 SHALL cover mid-operation reset: set busy[3] and busy[4] and rr_ptr=2, then pulse rst_n low between edges -> werf=0 and hazards clear immediately; the first grant with all requesters valid is requester 0.
